// File: rtl/multu_hilo_unit.sv
// Sequential unsigned shift-add multiplier with HI/LO result registers.
// It runs MULTU over WIDTH cycles and reads HI or LO back onto the datapath.
module multu_hilo_unit #(
  parameter int          WIDTH       = 32,
  parameter logic [5:0]  FUNCT_MULTU = 6'b011001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       SignaltoMULTU,
  input  logic [1:0]       SelHilo,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] dataOut,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MUL  = 1'b1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [0:0]         state;
  logic [WIDTH-1:0]   hi, lo;
  logic [2*WIDTH-1:0] mcand, prod, prod_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  // Adding the current iteration here lets the completion edge capture the full product.
  assign prod_nxt = mplier[0] ? (prod + mcand) : prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      hi     <= '0;
      lo     <= '0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (SignaltoMULTU == FUNCT_MULTU) begin
            mcand  <= {{WIDTH{1'b0}}, dataA};
            mplier <= dataB;
            prod   <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= MUL;
          end
        end
        default: begin
          prod   <= prod_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            hi    <= prod_nxt[2*WIDTH-1:WIDTH];
            lo    <= prod_nxt[WIDTH-1:0];
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    dataOut = '0;
    case (SelHilo)
      2'b01:   dataOut = hi;
      2'b10:   dataOut = lo;
      default: dataOut = '0;
    endcase
  end

endmodule

// File: tb/tb_multu_hilo_unit.sv
// Directed bench for multu_hilo_unit: latency, HI/LO results, busy-time reads,
// ignored restarts, mid-multiply reset and read-select decoding.
module tb_multu_hilo_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  SignaltoMULTU;
  logic [1:0]  SelHilo;
  logic [31:0] dataA, dataB, dataOut;
  logic        busy, done;

  int nchk = 0;
  int nfail = 0;

  multu_hilo_unit #(.WIDTH(32), .FUNCT_MULTU(6'b011001)) dut (
    .clk(clk), .rst(rst), .SignaltoMULTU(SignaltoMULTU), .SelHilo(SelHilo),
    .dataA(dataA), .dataB(dataB), .dataOut(dataOut), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Read HI or LO combinationally while the design is quiet.
  task automatic rd(input logic [1:0] sel, output logic [31:0] v);
    SelHilo = sel;
    #1 v = dataOut;
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
    logic [31:0] v;
    @(negedge clk);
    rd(2'b01, v); chk({tag, "_hi"}, v, ehi);
    rd(2'b10, v); chk({tag, "_lo"}, v, elo);
  endtask

  // Launch one multiply and watch 40 cycles; optional restart injection,
  // optional reset pulse, optional check of dataOut during every busy cycle.
  task automatic mul(input logic [31:0] a, input logic [31:0] b,
                     input int inj_at, input int rst_at,
                     input logic [1:0] sel, input bit chk_rd, input logic [31:0] rd_exp,
                     output int bc, output int dc);
    @(negedge clk);
    SignaltoMULTU = 6'd25; dataA = a; dataB = b; SelHilo = sel;
    @(posedge clk);
    #1 SignaltoMULTU = 6'd0; dataA = ~a; dataB = ~b;
    bc = 0; dc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) dc++;
      if (chk_rd && busy) chk("rd_during_busy", dataOut, rd_exp);
      if (i == inj_at) begin
        SignaltoMULTU = 6'd25; dataA = 32'hFFFF_FFFF; dataB = 32'hFFFF_FFFF;
      end else SignaltoMULTU = 6'd0;
      if (i == rst_at) begin
        rst = 1'b1; #2 rst = 1'b0;
      end
    end
  endtask

  initial begin
    int bc, dc;
    logic [31:0] v;
    rst = 1'b1; SignaltoMULTU = '0; SelHilo = 2'b00; dataA = '0; dataB = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    rd(2'b01, v); chk("rst_hi", v, 32'h0);
    rd(2'b10, v); chk("rst_lo", v, 32'h0);
    rst = 1'b0;

    mul(32'd7, 32'd9, -1, -1, 2'b10, 1'b0, 32'h0, bc, dc);
    chk("7x9_busy_cycles", bc, 32);
    chk("7x9_done_pulses", dc, 1);
    read_hilo("7x9", 32'h0, 32'h3F);

    mul(32'h10000, 32'h10000, -1, -1, 2'b10, 1'b1, 32'h3F, bc, dc);
    chk("big_done_pulses", dc, 1);
    read_hilo("10000sq", 32'h1, 32'h0);

    mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, 2'b00, 1'b0, 32'h0, bc, dc);
    read_hilo("maxsq", 32'hFFFF_FFFE, 32'h1);
    rd(2'b00, v); chk("sel00_zero", v, 32'h0);
    rd(2'b11, v); chk("sel11_zero", v, 32'h0);

    mul(32'h8000_0000, 32'd2, -1, -1, 2'b00, 1'b0, 32'h0, bc, dc);
    read_hilo("msbx2", 32'h1, 32'h0);

    // Restart at busy cycle 10 must be ignored: 0x12345678*0x10 = 0x1_2345_6780.
    mul(32'h1234_5678, 32'h10, 10, -1, 2'b00, 1'b0, 32'h0, bc, dc);
    chk("inj_busy_cycles", bc, 32);
    chk("inj_done_pulses", dc, 1);
    read_hilo("inj", 32'h1, 32'h2345_6780);

    mul(32'd7, 32'd9, -1, -1, 2'b00, 1'b0, 32'h0, bc, dc);
    read_hilo("pre_rst", 32'h0, 32'h3F);
    mul(32'hFFFF_FFFF, 32'h3, -1, 15, 2'b00, 1'b0, 32'h0, bc, dc);
    chk("rst_mid_done_pulses", dc, 0);
    chk("rst_mid_busy_cycles", bc, 16);
    chk("rst_mid_busy_now", busy, 1'b0);
    read_hilo("rst_mid", 32'h0, 32'h0);

    mul(32'd3, 32'd5, -1, -1, 2'b00, 1'b0, 32'h0, bc, dc);
    read_hilo("3x5", 32'h0, 32'hF);

    @(negedge clk);
    SignaltoMULTU = 6'b111111; dataA = 32'd4; dataB = 32'd4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("noop_busy", busy, 1'b0);
    end
    SignaltoMULTU = 6'd0;
    read_hilo("noop", 32'h0, 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
